// File: rtl/cpu_types_pkg.sv
// Shared datapath types for the pipelined CPU: word and register-index types,
// memory-stage FSM states and the LUI immediate shift.
package cpu_types_pkg;

  localparam int WORD_BITS = 32;
  localparam int REG_BITS  = 5;
  localparam int LUI_SHIFT = 16;

  typedef logic [WORD_BITS-1:0] word_t;
  typedef logic [REG_BITS-1:0]  regbits_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    HALTED
  } mem_state_t;

endpackage

// File: rtl/mem_wb_latch.sv
// MEM/WB pipeline register: a plain registered write-back bundle.
// Reset wins over bubble, and bubble wins over load.
module mem_wb_latch
  import cpu_types_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              load,
  input  logic              bubble,
  input  logic              dWen,
  input  regbits_t          dWsel,
  input  logic [WORD_W-1:0] dWdat,
  input  logic              dHalt,
  output logic              qWen,
  output regbits_t          qWsel,
  output logic [WORD_W-1:0] qWdat,
  output logic              qHalt
);

  // A bubble clears the slot so a stalled instruction never writes back early
  always_ff @(posedge CLK) begin
    if (RST || bubble) begin
      qWen  <= 1'b0;
      qWsel <= '0;
      qWdat <= '0;
      qHalt <= 1'b0;
    end else if (load) begin
      qWen  <= dWen;
      qWsel <= dWsel;
      qWdat <= dWdat;
      qHalt <= dHalt;
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory stage plus MEM/WB latch: data-cache handshake, branch resolve, write-back select.
// Optional MEM->EX forwarding outputs are enabled by defining MEM_WB_FWD_EN.
module mem_wb_stage
  import cpu_types_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              valid_in,
  input  logic              dREN_in,
  input  logic              dWEN_in,
  input  logic              bNE_in,
  input  logic              bEQ_in,
  input  logic              jAL_in,
  input  logic              lUI_in,
  input  logic              memtoReg_in,
  input  logic              regwr_in,
  input  logic              halt_in,
  input  logic              flagZero_in,
  input  logic [WORD_W-1:0] pcplusfour_in,
  input  logic [WORD_W-1:0] rdat2_in,
  input  logic [WORD_W-1:0] branch_addr_in,
  input  logic [WORD_W-1:0] alu_out_in,
  input  logic [15:0]       imm16_in,
  input  regbits_t          dest_reg_in,
  input  logic              dhit,
  input  logic [WORD_W-1:0] dmemload,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [WORD_W-1:0] dmemaddr,
  output logic [WORD_W-1:0] dmemstore,
  output logic              mem_stall,
  output logic              branch_taken,
  output logic [WORD_W-1:0] branch_target,
  output logic              wb_wen,
  output regbits_t          wb_wsel,
  output logic [WORD_W-1:0] wb_wdat,
  output logic              halt_out,
  output logic [31:0]       stall_cycles
`ifdef MEM_WB_FWD_EN
  ,
  output logic              fwd_wen,
  output regbits_t          fwd_wsel,
  output logic [WORD_W-1:0] fwd_wdat
`endif
);

  mem_state_t        state, nextState;
  logic              halted, reqActive, memOp, memStall;
  logic              nextWen, nextHalt;
  logic [WORD_W-1:0] nextWdat;

  assign halted    = (state == HALTED);
  assign reqActive = !RST && !halted;
  assign memOp     = valid_in && (dREN_in || dWEN_in);
  assign memStall  = reqActive && memOp && !dhit;

  // Simultaneous read and write is treated as a store, so the read is masked
  assign dmemREN   = reqActive && valid_in && dREN_in && !dWEN_in;
  assign dmemWEN   = reqActive && valid_in && dWEN_in;
  assign dmemaddr  = alu_out_in;
  assign dmemstore = rdat2_in;
  assign mem_stall = memStall;

  assign branch_taken  = !RST && valid_in &&
                         ((bEQ_in && flagZero_in) || (bNE_in && !flagZero_in));
  assign branch_target = branch_addr_in;

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= nextState;
  end

  // ACCESS simply tracks an outstanding request; HALTED only leaves via reset
  always_comb begin
    nextState = state;
    if (!halted) begin
      if (valid_in && halt_in && !memStall) nextState = HALTED;
      else if (memStall)                    nextState = ACCESS;
      else                                  nextState = IDLE;
    end
  end

  always_comb begin
    nextWdat = alu_out_in;
    if (jAL_in)           nextWdat = pcplusfour_in;
    else if (lUI_in)      nextWdat = WORD_W'(imm16_in) << LUI_SHIFT;
    else if (memtoReg_in) nextWdat = dmemload;
  end

  assign nextWen  = valid_in && regwr_in && (dest_reg_in != '0) && !halted;
  assign nextHalt = halted || (valid_in && halt_in);

  mem_wb_latch #(.WORD_W(WORD_W)) uLatch (
    .CLK    (CLK),
    .RST    (RST),
    .load   (!memStall),
    .bubble (memStall),
    .dWen   (nextWen),
    .dWsel  (dest_reg_in),
    .dWdat  (nextWdat),
    .dHalt  (nextHalt),
    .qWen   (wb_wen),
    .qWsel  (wb_wsel),
    .qWdat  (wb_wdat),
    .qHalt  (halt_out)
  );

  always_ff @(posedge CLK) begin
    if (RST)                            stall_cycles <= '0;
    else if (memStall && ~&stall_cycles) stall_cycles <= stall_cycles + 32'd1;
  end

`ifdef MEM_WB_FWD_EN
  assign fwd_wen  = memStall ? 1'b0 : nextWen;
  assign fwd_wsel = memStall ? '0   : dest_reg_in;
  assign fwd_wdat = memStall ? '0   : nextWdat;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage; write-back results are checked by a
// scoreboard monitor that pops one expectation per latched instruction.
module tb_mem_wb_stage;
  import cpu_types_pkg::*;

  logic        CLK, RST;
  logic        valid_in, dREN_in, dWEN_in, bNE_in, bEQ_in, jAL_in, lUI_in;
  logic        memtoReg_in, regwr_in, halt_in, flagZero_in, dhit;
  logic [31:0] pcplusfour_in, rdat2_in, branch_addr_in, alu_out_in, dmemload;
  logic [15:0] imm16_in;
  regbits_t    dest_reg_in;
  logic        dmemREN, dmemWEN, mem_stall, branch_taken, wb_wen, halt_out;
  logic [31:0] dmemaddr, dmemstore, branch_target, wb_wdat, stall_cycles;
  regbits_t    wb_wsel;

  typedef struct {
    string       name;
    logic        wen;
    logic [4:0]  wsel;
    logic [31:0] wdat;
    logic        halt;
  } exp_t;

  exp_t expQ[$];
  int   errors = 0;
  int   checks = 0;

  mem_wb_stage #(.WORD_W(32)) dut (
    .CLK(CLK), .RST(RST), .valid_in(valid_in), .dREN_in(dREN_in), .dWEN_in(dWEN_in),
    .bNE_in(bNE_in), .bEQ_in(bEQ_in), .jAL_in(jAL_in), .lUI_in(lUI_in),
    .memtoReg_in(memtoReg_in), .regwr_in(regwr_in), .halt_in(halt_in),
    .flagZero_in(flagZero_in), .pcplusfour_in(pcplusfour_in), .rdat2_in(rdat2_in),
    .branch_addr_in(branch_addr_in), .alu_out_in(alu_out_in), .imm16_in(imm16_in),
    .dest_reg_in(dest_reg_in), .dhit(dhit), .dmemload(dmemload),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .mem_stall(mem_stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .wb_wen(wb_wen), .wb_wsel(wb_wsel), .wb_wdat(wb_wdat), .halt_out(halt_out),
    .stall_cycles(stall_cycles)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic clearInputs();
    valid_in = 0; dREN_in = 0; dWEN_in = 0; bNE_in = 0; bEQ_in = 0; jAL_in = 0;
    lUI_in = 0; memtoReg_in = 0; regwr_in = 0; halt_in = 0; flagZero_in = 0; dhit = 0;
    pcplusfour_in = 0; rdat2_in = 0; branch_addr_in = 0; alu_out_in = 0;
    dmemload = 0; imm16_in = 0; dest_reg_in = 0;
  endtask

  task automatic applyStimulus();
    @(posedge CLK);
    #1;
    clearInputs();
  endtask

  task automatic pushExp(input string name, input logic wen, input logic [4:0] wsel,
                         input logic [31:0] wdat, input logic halt);
    exp_t e;
    e.name = name; e.wen = wen; e.wsel = wsel; e.wdat = wdat; e.halt = halt;
    expQ.push_back(e);
  endtask

  // Monitor: an instruction is latched on an edge when it is valid, unstalled and not in reset
  initial begin
    logic fire;
    exp_t e;
    forever begin
      @(negedge CLK);
      fire = !RST && valid_in && !mem_stall;
      @(posedge CLK);
      #2;
      if (fire) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected writeback", 32'd1, 32'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput({e.name, ".wen"}, {31'd0, wb_wen}, {31'd0, e.wen});
          checkOutput({e.name, ".halt"}, {31'd0, halt_out}, {31'd0, e.halt});
          if (e.wen) begin
            checkOutput({e.name, ".wsel"}, {27'd0, wb_wsel}, {27'd0, e.wsel});
            checkOutput({e.name, ".wdat"}, wb_wdat, e.wdat);
          end
        end
      end else begin
        checkOutput("bubble.wen", {31'd0, wb_wen}, 32'd0);
      end
    end
  end

  initial begin
    clearInputs();
    RST = 1'b1;
    valid_in = 1; dREN_in = 1; bEQ_in = 1; flagZero_in = 1;
    @(posedge CLK); #1;
    @(negedge CLK);
    checkOutput("rst.dmemREN", {31'd0, dmemREN}, 32'd0);
    checkOutput("rst.mem_stall", {31'd0, mem_stall}, 32'd0);
    checkOutput("rst.branch_taken", {31'd0, branch_taken}, 32'd0);
    checkOutput("rst.wb_wen", {31'd0, wb_wen}, 32'd0);
    checkOutput("rst.wb_wdat", wb_wdat, 32'd0);
    checkOutput("rst.halt_out", {31'd0, halt_out}, 32'd0);
    checkOutput("rst.stall_cycles", stall_cycles, 32'd0);

    applyStimulus(); RST = 1'b0;
    valid_in = 1; regwr_in = 1; dest_reg_in = 5; alu_out_in = 32'h1234;
    pushExp("alu", 1, 5, 32'h1234, 0);
    @(negedge CLK);
    checkOutput("alu.mem_stall", {31'd0, mem_stall}, 32'd0);

    applyStimulus();
    valid_in = 1; dREN_in = 1; memtoReg_in = 1; regwr_in = 1; dest_reg_in = 7;
    alu_out_in = 32'h100;
    pushExp("load", 1, 7, 32'hDEADBEEF, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checkOutput("load.dmemREN", {31'd0, dmemREN}, 32'd1);
      checkOutput("load.mem_stall", {31'd0, mem_stall}, 32'd1);
      checkOutput("load.dmemaddr", dmemaddr, 32'h100);
      @(posedge CLK); #1;
    end
    dhit = 1; dmemload = 32'hDEADBEEF;
    @(negedge CLK);
    checkOutput("load.hit_stall", {31'd0, mem_stall}, 32'd0);
    checkOutput("load.hit_dmemREN", {31'd0, dmemREN}, 32'd1);
    applyStimulus();
    @(negedge CLK);
    checkOutput("load.stall_cycles", stall_cycles, 32'd3);

    applyStimulus();
    valid_in = 1; dWEN_in = 1; dhit = 1; rdat2_in = 32'hCAFE0001; alu_out_in = 32'h200;
    pushExp("store", 0, 0, 0, 0);
    @(negedge CLK);
    checkOutput("store.dmemWEN", {31'd0, dmemWEN}, 32'd1);
    checkOutput("store.dmemREN", {31'd0, dmemREN}, 32'd0);
    checkOutput("store.dmemstore", dmemstore, 32'hCAFE0001);
    checkOutput("store.mem_stall", {31'd0, mem_stall}, 32'd0);

    applyStimulus();
    valid_in = 1; dREN_in = 1; dWEN_in = 1; dhit = 1;
    pushExp("rdwr", 0, 0, 0, 0);
    @(negedge CLK);
    checkOutput("rdwr.dmemREN", {31'd0, dmemREN}, 32'd0);
    checkOutput("rdwr.dmemWEN", {31'd0, dmemWEN}, 32'd1);

    applyStimulus();
    valid_in = 1; bNE_in = 1; flagZero_in = 0; branch_addr_in = 32'h40;
    pushExp("bne_t", 0, 0, 0, 0);
    @(negedge CLK);
    checkOutput("bne_t.taken", {31'd0, branch_taken}, 32'd1);
    checkOutput("bne_t.target", branch_target, 32'h40);

    applyStimulus();
    valid_in = 1; bNE_in = 1; flagZero_in = 1; branch_addr_in = 32'h40;
    pushExp("bne_nt", 0, 0, 0, 0);
    @(negedge CLK);
    checkOutput("bne_nt.taken", {31'd0, branch_taken}, 32'd0);

    applyStimulus();
    valid_in = 1; bEQ_in = 1; flagZero_in = 1; branch_addr_in = 32'h80;
    pushExp("beq_t", 0, 0, 0, 0);
    @(negedge CLK);
    checkOutput("beq_t.taken", {31'd0, branch_taken}, 32'd1);
    checkOutput("beq_t.target", branch_target, 32'h80);

    applyStimulus();
    bEQ_in = 1; flagZero_in = 1;
    @(negedge CLK);
    checkOutput("bubble_beq.taken", {31'd0, branch_taken}, 32'd0);

    applyStimulus();
    valid_in = 1; lUI_in = 1; memtoReg_in = 1; regwr_in = 1; dest_reg_in = 3;
    imm16_in = 16'hABCD; dmemload = 32'h55;
    pushExp("lui", 1, 3, 32'hABCD0000, 0);

    applyStimulus();
    valid_in = 1; jAL_in = 1; lUI_in = 1; regwr_in = 1; dest_reg_in = 31;
    pcplusfour_in = 32'h1004; imm16_in = 16'hFFFF;
    pushExp("jal", 1, 31, 32'h1004, 0);

    applyStimulus();
    valid_in = 1; regwr_in = 1; dest_reg_in = 0; alu_out_in = 32'h99;
    pushExp("reg0", 0, 0, 0, 0);

    applyStimulus();
    valid_in = 1; halt_in = 1;
    pushExp("halt", 0, 0, 0, 1);
    @(negedge CLK);
    checkOutput("halt.mem_stall", {31'd0, mem_stall}, 32'd0);

    applyStimulus();
    valid_in = 1; dREN_in = 1; memtoReg_in = 1; regwr_in = 1; dest_reg_in = 4;
    alu_out_in = 32'h300;
    pushExp("halted_ld", 0, 0, 0, 1);
    @(negedge CLK);
    checkOutput("halted.dmemREN", {31'd0, dmemREN}, 32'd0);
    checkOutput("halted.mem_stall", {31'd0, mem_stall}, 32'd0);
    checkOutput("halted.halt_out", {31'd0, halt_out}, 32'd1);

    applyStimulus(); RST = 1'b1;
    applyStimulus(); RST = 1'b0;
    @(negedge CLK);
    checkOutput("unhalt.halt_out", {31'd0, halt_out}, 32'd0);

    applyStimulus();
    valid_in = 1; dREN_in = 1; memtoReg_in = 1; regwr_in = 1; dest_reg_in = 9;
    alu_out_in = 32'h400;
    @(negedge CLK);
    checkOutput("access.dmemREN", {31'd0, dmemREN}, 32'd1);
    @(posedge CLK); #1;
    @(negedge CLK);
    checkOutput("access.mem_stall", {31'd0, mem_stall}, 32'd1);
    @(posedge CLK); #1;
    @(negedge CLK);
    checkOutput("access.stall_cycles", stall_cycles, 32'd2);
    RST = 1'b1;
    #1;
    checkOutput("rst_access.dmemREN", {31'd0, dmemREN}, 32'd0);
    checkOutput("rst_access.mem_stall", {31'd0, mem_stall}, 32'd0);
    applyStimulus();
    @(negedge CLK);
    checkOutput("rst_access.wb_wen", {31'd0, wb_wen}, 32'd0);
    checkOutput("rst_access.wb_wsel", {27'd0, wb_wsel}, 32'd0);
    checkOutput("rst_access.wb_wdat", wb_wdat, 32'd0);
    checkOutput("rst_access.halt_out", {31'd0, halt_out}, 32'd0);
    checkOutput("rst_access.stall_cycles", stall_cycles, 32'd0);
    RST = 1'b0;

    repeat (3) applyStimulus();
    checkOutput("scoreboard.drained", expQ.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory stage plus MEM/WB pipeline register of the pipelined datapath. Consumes the latched EX/MEM bundle, drives the data-cache request with a hold-until-`dhit` handshake, resolves BEQ/BNE, and selects write-back data (load, LUI, JAL link, ALU). The result is registered into the MEM/WB latch feeding the register file. `mem_stall` is exported to the hazard unit.

## Interface
- `WORD_W`, 32: datapath word width.
- `CLK` in 1: sole clock; all state updates on the rising edge.
- `RST` in 1: synchronous, active-high reset.
- `valid_in` in 1: EX/MEM slot holds a real instruction (0 = bubble).
- `dREN_in`, `dWEN_in`, `bNE_in`, `bEQ_in`, `jAL_in`, `lUI_in`, `memtoReg_in`, `regwr_in`, `halt_in` in 1 each: EX/MEM control.
- `flagZero_in` in 1: ALU zero flag.
- `pcplusfour_in`, `rdat2_in`, `branch_addr_in`, `alu_out_in` in WORD_W: EX/MEM data.
- `imm16_in` in 16: LUI immediate.
- `dest_reg_in` in 5: destination register.
- `dhit` in 1: cache completed the current request.
- `dmemload` in WORD_W: load data, valid when `dhit`.
- `dmemREN`, `dmemWEN` out 1: cache request.
- `dmemaddr`, `dmemstore` out WORD_W: address (`alu_out_in`) and store data (`rdat2_in`).
- `mem_stall` out 1: freeze IF/ID/EX and the EX/MEM latch.
- `branch_taken` out 1, `branch_target` out WORD_W: to PC select.
- `wb_wen` out 1, `wb_wsel` out 5, `wb_wdat` out WORD_W, `halt_out` out 1: registered MEM/WB outputs.
- `stall_cycles` out 32: saturating count of cycles with `mem_stall`=1.

## Operation
- FSM states: IDLE, ACCESS, HALTED.
- A memory op is `valid_in & (dREN_in | dWEN_in)`.
- IDLE:
  - Memory op with `dhit`=0: go to ACCESS.
  - Memory op with `dhit`=1 in the same cycle: stay in IDLE and complete.
- ACCESS: remains while `dhit`=0; returns to IDLE on `dhit`.
- Request signals:
  - `dmemREN` = `valid_in & dREN_in` in IDLE/ACCESS; `dmemWEN` likewise.
  - Both are held stable until `dhit`.
  - Both are 0 in HALTED and during reset.
- `dREN_in & dWEN_in` together: treated as a store only; `dmemREN` is forced to 0.
- `mem_stall` = memory op & `!dhit` (combinational). A bubble never stalls.
- `branch_taken` = `valid_in & ((bEQ_in & flagZero_in) | (bNE_in & !flagZero_in))`.
  - Combinational; `branch_target` = `branch_addr_in`.
  - It is not suppressed by `mem_stall`; the hazard unit gives stall priority.
- Write-data select priority: `jAL_in` → `pcplusfour_in`; `lUI_in` → `{imm16_in,16'h0}`; `memtoReg_in` → `dmemload`; otherwise `alu_out_in`.
- MEM/WB latch:
  - Loads when `!mem_stall`.
  - If `mem_stall`=1, a bubble is loaded (`wb_wen`=0). A stalled load never writes twice.
  - `wb_wen` = `valid_in & regwr_in & (dest_reg_in != 0)`.
- Halt:
  - `valid_in & halt_in` with no stall registers `halt_out`=1 and enters HALTED.
  - HALTED is sticky until `RST`.
  - In HALTED, `wb_wen` is held at 0.
- `stall_cycles` increments each cycle `mem_stall`=1 and saturates at 0xFFFF_FFFF.

## Timing
- Non-memory op: write-back outputs are valid 1 cycle after the op is presented.
- Memory op: result is registered on the edge where `dhit`=1.
  - Latency is 1 + N cycles, where N is the number of wait cycles.
- Reset (synchronous, takes priority over everything):
  - State = IDLE.
  - `wb_wen`=0, `wb_wsel`=0, `wb_wdat`=0, `halt_out`=0, `stall_cycles`=0.
  - The combinational outputs `dmemREN`, `dmemWEN`, `mem_stall`, `branch_taken` are forced to 0 while `RST`=1.
- `RST` mid-ACCESS: the request drops in that cycle and nothing is written back.

## Configuration
- `MEM_WB_FWD_EN` defined: adds outputs `fwd_wen` (1), `fwd_wsel` (5), `fwd_wdat` (WORD_W).
  - These are the combinational pre-latch `wb_*` values, used for MEM→EX forwarding.
  - They are zero while `mem_stall`.
- `MEM_WB_FWD_EN` undefined: the ports are absent. The hazard unit must stall on RAW hazards across MEM.

## Structure
- `cpu_types_pkg`:
  - `word_t`, `regbits_t`.
  - `mem_state_t` enum {IDLE, ACCESS, HALTED}.
  - `LUI_SHIFT`=16.
- One sub-module, `mem_wb_latch`: a plain registered bundle with load/bubble/reset inputs.
- The FSM, counter and muxing live in `mem_wb_stage`.

## Test plan
- ALU op: `alu_out_in`=0x1234, `dest_reg_in`=5, `regwr_in`=1 → next cycle `wb_wen`=1, `wb_wsel`=5, `wb_wdat`=0x1234; `mem_stall` never 1.
- Load with `dhit` delayed 3 cycles, `dmemload`=0xDEADBEEF:
  - `dmemREN`=1 and `mem_stall`=1 for 3 cycles.
  - `wb_wdat`=0xDEADBEEF registered once.
  - `stall_cycles`=3.
- Store with same-cycle `dhit`: `dmemWEN`=1 for 1 cycle, `dmemstore`=`rdat2_in`, no stall, `wb_wen`=0.
- BNE with `flagZero_in`=0, `branch_addr_in`=0x40 → `branch_taken`=1, `branch_target`=0x40. With `flagZero_in`=1 → `branch_taken`=0.
- LUI `imm16_in`=0xABCD → `wb_wdat`=0xABCD0000. JAL → `wb_wdat`=`pcplusfour_in`. A write to reg 0 gives `wb_wen`=0.
- Halt, then RST:
  - Halt → `halt_out`=1 and a later `dREN_in` gives no request.
  - `RST` asserted mid-ACCESS → the next cycle has all outputs at reset values.
